// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 binary32 divider: one quotient bit per cycle by restoring division,
// truncating rounding, flushed denormals, and adder-compatible neg/zero/carry/overflow flags.
module fp_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        neg,
  output logic        zero,
  output logic        carry,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic [24:0]       rem;
  logic [23:0]       dv;
  logic [24:0]       q;
  logic signed [9:0] exp_r;
  logic              s_r;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic        s_in;

  assign s_in = a[31] ^ b[31];
  assign ea   = a[30:23];
  assign eb   = b[30:23];
  assign ma   = {1'b1, a[22:0]};
  assign mb   = {1'b1, b[22:0]};

  // rem < 2*dv always holds, so a successful subtraction leaves less than dv (< 2^24).
  logic        rem_ge;
  logic [23:0] rem_diff;

  assign rem_ge   = rem >= {1'b0, dv};
  assign rem_diff = rem[23:0] - dv;

  logic signed [9:0] exp_n;
  logic [22:0]       man_n;
  logic [33:0]       pack_n;

  assign exp_n = q[24] ? exp_r : exp_r - 10'sd1;
  assign man_n = q[24] ? q[23:1] : q[22:0];

  // Returns {overflow, zero, result}; out-of-range exponents saturate to infinity or zero.
  function automatic logic [33:0] sat_pack(input logic sgn,
                                           input logic signed [9:0] e,
                                           input logic [22:0] m);
    logic [33:0] r;
    if (e >= 10'sd255)
      r = {1'b1, 1'b0, sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      r = {1'b0, 1'b1, sgn, 31'd0};
    else
      r = {2'b00, sgn, e[7:0], m};
    return r;
  endfunction

  assign pack_n = sat_pack(s_r, exp_n, man_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dv       <= '0;
      q        <= '0;
      exp_r    <= '0;
      s_r      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      neg      <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // IDLE: accept, resolve zero operands immediately, else load the divider
        IDLE: begin
          if (start) begin
            if (ea == 8'd0 && eb == 8'd0) begin
              result   <= 32'h7FC0_0000;
              neg      <= 1'b0;
              zero     <= 1'b0;
              carry    <= 1'b0;
              overflow <= 1'b1;
              done     <= 1'b1;
            end else if (eb == 8'd0) begin
              result   <= {s_in, 8'hFF, 23'd0};
              neg      <= s_in;
              zero     <= 1'b0;
              carry    <= 1'b0;
              overflow <= 1'b1;
              done     <= 1'b1;
            end else if (ea == 8'd0) begin
              result   <= {s_in, 31'd0};
              neg      <= s_in;
              zero     <= 1'b1;
              carry    <= 1'b0;
              overflow <= 1'b0;
              done     <= 1'b1;
            end else begin
              rem   <= {1'b0, ma};
              dv    <= mb;
              q     <= '0;
              exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
              cnt   <= 5'd24;
              s_r   <= s_in;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        // CALC: 25 restoring iterations produce floor((ma << 24) / mb)
        CALC: begin
          if (rem_ge) begin
            q   <= {q[23:0], 1'b1};
            rem <= {rem_diff, 1'b0};
          end else begin
            q   <= {q[23:0], 1'b0};
            rem <= {rem[23:0], 1'b0};
          end
          if (cnt == 5'd0)
            state <= NORM;
          else
            cnt <= cnt - 5'd1;
        end
        // NORM: one-bit normalise, saturate, publish
        NORM: begin
          result   <= pack_n[31:0];
          overflow <= pack_n[33];
          zero     <= pack_n[32];
          neg      <= s_r;
          carry    <= (rem != 25'd0) || (q[24] && q[0]);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: normal, special-case, saturation and reset-abort vectors.
module tb_fp_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        neg;
  logic        zero;
  logic        carry;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  fp_div dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .neg      (neg),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Flags are compared as {neg, zero, carry, overflow}.
  task automatic chk_out(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".flags"}, {28'd0, neg, zero, carry, overflow}, {28'd0, exp_fl});
  endtask

  // Issue one request and wait (bounded) for done. Operands are scrambled after
  // acceptance to confirm they were captured. With hold, start stays high while busy.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit hold,
                       output int lat, output int busy_cnt, output int extra_done);
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    extra_done = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      if (!hold) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (done) extra_done++;
  endtask

  task automatic run_norm(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input bit hold, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int lat, bc, xd;
    do_op(ta, tb_v, hold, lat, bc, xd);
    chk({tag, ".latency"}, lat, 32'd27);
    chk({tag, ".busy_cycles"}, bc, 32'd26);
    chk({tag, ".done_width"}, xd, 32'd0);
    chk_out(tag, exp_res, exp_fl);
  endtask

  task automatic run_spec(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int lat, bc, xd;
    do_op(ta, tb_v, 1'b0, lat, bc, xd);
    chk({tag, ".latency"}, lat, 32'd1);
    chk({tag, ".busy_cycles"}, bc, 32'd0);
    chk({tag, ".done_width"}, xd, 32'd0);
    chk_out(tag, exp_res, exp_fl);
  endtask

  initial begin
    int dones;
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk_out("reset", 32'h0, 4'b0000);
    reset = 1'b1;
    @(negedge clk);

    run_norm("six_div_two", 32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);
    run_norm("one_third",   32'h3F80_0000, 32'h4040_0000, 1'b0, 32'h3EAA_AAAA, 4'b0010);
    run_norm("neg_hold",    32'hBFC0_0000, 32'h3F00_0000, 1'b1, 32'hC040_0000, 4'b1000);
    chk("neg_hold.idle_after", {31'd0, busy}, 32'd0);

    // Abort at cycle 10 of CALC with an asynchronous reset.
    @(negedge clk);
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk_out("abort", 32'h0, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort.no_done", dones, 32'd0);
    chk_out("abort.held", 32'h0, 4'b0000);

    run_norm("after_abort", 32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);

    run_spec("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001);
    run_spec("zero_div",    32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100);
    run_spec("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001);
    run_spec("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b1001);

    run_norm("exp_over",  32'h7F00_0000, 32'h3E80_0000, 1'b0, 32'h7F80_0000, 4'b0001);
    run_norm("exp_under", 32'h0080_0000, 32'h7F00_0000, 1'b0, 32'h0000_0000, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
